// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic phase scheduler and the traffic light
// controller variants: FSM state encodings and default sizing.
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int N_PHASES_DEF = 4;
    localparam int CNT_W_DEF    = 8;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin select. The search starts at last+1 and wraps
// modulo N; the first set bit of pending found in that order is granted.
//   pending : request vector, one bit per phase
//   last    : index of the most recently granted phase
//   grant   : index of the selected phase (equals last when nothing is pending)
//   valid   : high when any pending bit is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest pending phase
    // after 'last' overwrites any earlier hit.
    always_comb begin
        grant = last;
        valid = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IDX_W'((int'(last) + k) % N);
            if (pending[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// -----------------------------------------------------------------------------
// traffic_phase_scheduler
// Round-robin intersection phase scheduler. Latches per-phase requests and
// cycles GREEN -> YELLOW -> ALL_RED for one phase at a time. Durations are
// counted in ticks of an external enable pulse.
//   clk, rst (async, active-low), tick (timebase enable)
//   req          : level request sensors, one per phase
//   min_green, max_green, yellow_time, allred_time : durations in ticks
//   green/yellow/red : registered lamp drives, red = ~(green|yellow)
//   active_phase : last/current granted phase
//   phase_start  : one-cycle pulse on entry to GREEN
// -----------------------------------------------------------------------------
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_PHASES = N_PHASES_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int PH_W     = $clog2(N_PHASES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [N_PHASES-1:0] req,
    input  logic [CNT_W-1:0]    min_green,
    input  logic [CNT_W-1:0]    max_green,
    input  logic [CNT_W-1:0]    yellow_time,
    input  logic [CNT_W-1:0]    allred_time,
    output logic [N_PHASES-1:0] green,
    output logic [N_PHASES-1:0] yellow,
    output logic [N_PHASES-1:0] red,
    output logic [PH_W-1:0]     active_phase,
    output logic                phase_start
);

    localparam logic [CNT_W-1:0] TIMER_MAX = '1;

    state_t                state;
    logic [CNT_W-1:0]      timer;
    logic [N_PHASES-1:0]   pending;
    logic [N_PHASES-1:0]   pending_set;
    logic [N_PHASES-1:0]   active_oh;
    logic [N_PHASES-1:0]   grant_oh;
    logic [PH_W-1:0]       grant;
    logic                  grant_valid;
    logic [CNT_W-1:0]      max_eff;
    logic                  min_exp;
    logic                  max_exp;
    logic                  yellow_exp;
    logic                  allred_exp;
    logic                  allred_ready;
    logic                  other_pending;
    logic                  leave_green;

    // True when the timer, advanced by this tick, reaches duration d.
    // A zero duration behaves as one tick.
    function automatic logic reached(input logic [CNT_W-1:0] t,
                                     input logic [CNT_W-1:0] d);
        logic [CNT_W-1:0] d_eff;
        logic [CNT_W:0]   t_next;
        d_eff  = (d == '0) ? CNT_W'(1) : d;
        t_next = {1'b0, t} + (CNT_W+1)'(1);
        return t_next >= {1'b0, d_eff};
    endfunction

    function automatic logic [N_PHASES-1:0] to_onehot(input logic [PH_W-1:0] i);
        return N_PHASES'(1) << i;
    endfunction

    rr_arbiter #(
        .N     (N_PHASES),
        .IDX_W (PH_W)
    ) u_arb (
        .pending (pending),
        .last    (active_phase),
        .grant   (grant),
        .valid   (grant_valid)
    );

    assign active_oh = to_onehot(active_phase);
    assign grant_oh  = to_onehot(grant);

    // A max shorter than min is stretched to min.
    assign max_eff    = (max_green < min_green) ? min_green : max_green;
    assign min_exp    = tick && reached(timer, min_green);
    assign max_exp    = tick && reached(timer, max_eff);
    assign yellow_exp = tick && reached(timer, yellow_time);
    assign allred_exp = tick && reached(timer, allred_time);

    // A saturated timer in ALL_RED marks clearance as already served, so a
    // late request is granted without waiting for another tick.
    assign allred_ready = allred_exp || (timer == TIMER_MAX);

    assign other_pending = |(pending & ~active_oh);
    assign leave_green   = min_exp && other_pending &&
                           (((req & active_oh) == '0) || max_exp);

    // The green phase's own request is extension demand, not a new request.
    assign pending_set = pending | (req & ((state == ST_GREEN) ? ~active_oh : '1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_ALL_RED;
            timer        <= '0;
            pending      <= '0;
            active_phase <= PH_W'(N_PHASES - 1);
            green        <= '0;
            yellow       <= '0;
            red          <= '1;
            phase_start  <= 1'b0;
        end else begin
            phase_start <= 1'b0;
            pending     <= pending_set;
            if (tick && (timer != TIMER_MAX))
                timer <= timer + CNT_W'(1);

            case (state)
                ST_ALL_RED: begin
                    if (allred_ready && grant_valid) begin
                        state        <= ST_GREEN;
                        timer        <= '0;
                        active_phase <= grant;
                        phase_start  <= 1'b1;
                        pending      <= pending_set & ~grant_oh;
                        green        <= grant_oh;
                        yellow       <= '0;
                        red          <= ~grant_oh;
                    end else if (allred_exp) begin
                        timer <= TIMER_MAX;
                    end
                end
                ST_GREEN: begin
                    if (leave_green) begin
                        state  <= ST_YELLOW;
                        timer  <= '0;
                        green  <= '0;
                        yellow <= active_oh;
                        red    <= ~active_oh;
                    end
                end
                ST_YELLOW: begin
                    if (yellow_exp) begin
                        state  <= ST_ALL_RED;
                        timer  <= '0;
                        green  <= '0;
                        yellow <= '0;
                        red    <= '1;
                    end
                end
                default: begin
                    state  <= ST_ALL_RED;
                    timer  <= '0;
                    green  <= '0;
                    yellow <= '0;
                    red    <= '1;
                end
            endcase
        end
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Multi-approach phase scheduler for an intersection. It latches vehicle and pedestrian requests from N approaches and grants green to one phase at a time, using round-robin order. Every green is followed by a yellow and then an all-red clearance. Timing is programmable in ticks of an external enable pulse, and the outputs drive the per-approach lamp drivers directly.

Parameters:
N_PHASES, 4, number of approaches/phases (2..8)
CNT_W, 8, width of the tick timer and of every duration input
PH_W, 2, width of the phase index (clog2(N_PHASES))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
tick  input  1  one-cycle timebase enable (e.g. 1 Hz); timers advance only when tick=1
req  input  N_PHASES  level sensor requests, one per phase
min_green  input  CNT_W  minimum green duration, ticks
max_green  input  CNT_W  maximum green duration when conflicting demand exists, ticks
yellow_time  input  CNT_W  yellow duration, ticks
allred_time  input  CNT_W  all-red clearance duration, ticks
green  output  N_PHASES  one-hot green lamps
yellow  output  N_PHASES  one-hot yellow lamps
red  output  N_PHASES  red lamps = ~(green|yellow)
active_phase  output  PH_W  index of the last/current granted phase
phase_start  output  1  one-cycle pulse on entry to GREEN

Behaviour:
- Reset (rst=0, async): state=ALL_RED, timer=0, pending=0, active_phase=N_PHASES-1, green=0, yellow=0, red=all 1s, phase_start=0. Reset mid-cycle forces all-red immediately.
- All outputs are registered; lamps change on the clock edge of the state transition.
- pending[i] is set on any cycle where req[i]=1, except for the active phase while in GREEN. That request is used as extension demand instead.
- pending[i] clears on the edge the phase enters GREEN.
- Durations of 0 are treated as 1. "Expiry" of duration D means tick=1 and timer+1 >= D. Timer resets to 0 on every state change and saturates at 2^CNT_W-1.
- Duration inputs are sampled continuously; a change takes effect at the next compare.
- ALL_RED: on expiry, if pending!=0, go to GREEN on the next pending phase.
  - Search order is active_phase+1 upward, wrapping modulo N_PHASES.
  - Set active_phase, pulse phase_start, clear that pending bit.
  - If pending==0, rest in ALL_RED with the timer saturated; grant on the first cycle pending becomes nonzero (no tick needed once allred expired).
- GREEN: leave to YELLOW when min_green has expired AND any other phase is pending AND one of the following holds:
  - req[active_phase]=0 (gap-out), or
  - max_green has expired (max-out).
  - With no conflicting demand, green rests indefinitely.
  - If max_green < min_green, min_green governs.
- YELLOW: on yellow_time expiry go to ALL_RED.
- Simultaneous events: a request for the yellow/clearing phase arriving during YELLOW or ALL_RED is latched into pending and served in its round-robin turn, not immediately re-granted ahead of others.
- Starvation bound: each pending phase is served within N_PHASES-1 other greens.
- Invariants: at most one bit of green|yellow is set; never green and yellow in the same cycle.

Decomposition:
- Shared package/include traffic_pkg holds:
  - state encodings ST_ALL_RED=2'd0, ST_GREEN=2'd1, ST_YELLOW=2'd2
  - default N_PHASES and CNT_W
  - these are shared with traffic_light_controller variants.
- Sub-module rr_arbiter (N, pending vector, last index -> grant index + valid) is combinational round-robin select; it is instantiated once.
- Timer and FSM stay in the top.

Test Plan:
- Reset then req=4'b0000 for 50 ticks -> red=4'b1111, green=0, phase_start never pulses; rst low mid-GREEN -> red=4'b1111 the same cycle (async).
- min_green=3, yellow=2, allred=1; pulse req[2] once -> after 1 allred tick green=4'b0100, active_phase=2, one phase_start pulse; green rests with no other demand.
- Phase 0 green with req[0] held, req[1] asserted at tick 1, min=3, max=6 -> yellow[0] after exactly 6 ticks (max-out), 2 ticks yellow, 1 all-red, then green=4'b0010.
- Same setup but req[0] drops at tick 4 -> yellow[0] at tick 4 (gap-out, after min 3).
- active_phase=1 in GREEN, req=4'b1101 pending -> grants follow order 2,3,0; each served exactly once before any repeat.
- min_green=0, yellow_time=0, allred_time=0 -> every state lasts exactly 1 tick; no cycle ever has two lamps set for one phase.
